// File: rtl/encoder_8to3_rr.sv
// -----------------------------------------------------------------------------
// encoder_8to3_rr
//
// Registered 8-to-3 request encoder. It samples eight level request lines,
// picks one winner, holds the winner's index on A behind a Valid/Ready
// handshake, and returns a one-cycle one-hot Grant on the winning line once
// the index is accepted. A = k always refers to R[k], so A can drive the
// select inputs of a matching 3-to-8 write-select decoder directly.
//
// Build option (compile-time macro):
//   ENCODER_ROUND_ROBIN_EN  defined   -> rotating priority. The search starts
//                                        at pointer P and wraps 7 -> 0. P
//                                        moves to A+1 on every acceptance.
//   ENCODER_ROUND_ROBIN_EN  undefined -> fixed priority. The lowest set bit
//                                        wins, and no pointer exists.
//
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  synchronous active-high reset, highest priority
//   Enable  in   1  allows a new capture while idle (no effect while holding)
//   R       in   8  level request lines
//   Ready   in   1  consumer accepts A while Valid is high
//   A       out  3  registered winning index
//   Valid   out  1  A holds a captured, not yet accepted index
//   Multi   out  1  more than one request was set at capture
//   Grant   out  8  one-hot acknowledge, high for the single cycle after
//                   acceptance
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module encoder_8to3_rr (
    input  logic       clk,
    input  logic       reset,
    input  logic       Enable,
    input  logic [7:0] R,
    input  logic       Ready,
    output logic [2:0] A,
    output logic       Valid,
    output logic       Multi,
    output logic [7:0] Grant
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0] state_q, state_d;
    logic [2:0] a_q,     a_d;
    logic       valid_q, valid_d;
    logic       multi_q, multi_d;
    logic [7:0] grant_q, grant_d;

    // Search base. In the fixed-priority build it is a constant zero, so the
    // rotation below reduces to plain wiring.
    logic [2:0] base;

`ifdef ENCODER_ROUND_ROBIN_EN
    logic [2:0] p_q, p_d;
    assign base = p_q;
`else
    assign base = 3'd0;
`endif

    // Rotate the requests so that rot_req[0] is the line at the search base.
    // The 3-bit sum wraps naturally, which gives the 7 -> 0 wrap-around.
    logic [7:0] rot_req;
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_rot
            assign rot_req[gi] = R[base + 3'(gi)];
        end
    endgenerate

    // The lowest set bit of the rotated vector is the winner's offset from
    // the base. The loop scans downward so that the lowest bit is written last
    // and therefore wins.
    logic [2:0] win_off;
    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_off = 3'(i);
            end
        end
    end

    logic [2:0] win_idx;
    assign win_idx = base + win_off;

    // "More than one bit set" is true when clearing the lowest set bit still
    // leaves something behind. This avoids building a full popcount.
    logic multi_req;
    assign multi_req = |(R & (R - 8'd1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        valid_d = valid_q;
        multi_d = multi_q;
        grant_d = 8'd0;
`ifdef ENCODER_ROUND_ROBIN_EN
        p_d     = p_q;
`endif
        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (Enable && (R != 8'd0)) begin
                    a_d     = win_idx;
                    multi_d = multi_req;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A, Valid and Multi stay frozen until acceptance. Changes on
                // R and Enable are deliberately ignored here.
                if (Ready) begin
                    grant_d = 8'd1 << a_q;
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
`ifdef ENCODER_ROUND_ROBIN_EN
                    p_d     = a_q + 3'd1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= 3'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            grant_q <= 8'd0;
`ifdef ENCODER_ROUND_ROBIN_EN
            p_q     <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
            grant_q <= grant_d;
`ifdef ENCODER_ROUND_ROBIN_EN
            p_q     <= p_d;
`endif
        end
    end

    assign A     = a_q;
    assign Valid = valid_q;
    assign Multi = multi_q;
    assign Grant = grant_q;

endmodule

// File: tb/tb_encoder_8to3_rr.sv
// -----------------------------------------------------------------------------
// tb_encoder_8to3_rr
//
// Testbench for encoder_8to3_rr.
//
// Stimulus is a per-cycle table. Each row gives the inputs to apply before a
// rising edge and the outputs expected just after that edge. A short sequence
// written out by hand then covers a bounded wait for Valid and the absence of
// any combinational path from inputs to outputs. Expected values that differ
// between the round-robin and fixed-priority builds are selected by the same
// build macro, ENCODER_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_encoder_8to3_rr;

`ifdef ENCODER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       Enable;
    logic [7:0] R;
    logic       Ready;
    logic [2:0] A;
    logic       Valid;
    logic       Multi;
    logic [7:0] Grant;

    encoder_8to3_rr dut (
        .clk    (clk),
        .reset  (reset),
        .Enable (Enable),
        .R      (R),
        .Ready  (Ready),
        .A      (A),
        .Valid  (Valid),
        .Multi  (Multi),
        .Grant  (Grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       en;
        bit [7:0] r;
        bit       rdy;
        bit       ev;     // expected Valid
        bit       chk_a;  // A and Multi are only meaningful on some rows
        bit [2:0] ea;
        bit       em;
        bit [7:0] eg;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int row,
                         input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit rst, bit en, bit [7:0] r, bit rdy, bit ev,
                                bit chk_a, bit [2:0] ea, bit em, bit [7:0] eg);
        vec_t v;
        v.rst = rst; v.en = en; v.r = r; v.rdy = rdy; v.ev = ev;
        v.chk_a = chk_a; v.ea = ea; v.em = em; v.eg = eg;
        return v;
    endfunction

    initial begin
        // The P comments track the round-robin pointer after each row.
        // Reset for two cycles while requests are active.
        vecs[0]  = mk(1, 1, 8'hFF, 0, 0, 1, 3'd0, 0, 8'h00);
        vecs[1]  = mk(1, 1, 8'hFF, 0, 0, 1, 3'd0, 0, 8'h00);
        // Single request on line 2, then acceptance. P becomes 3.
        vecs[2]  = mk(0, 1, 8'h04, 0, 1, 1, 3'd2, 0, 8'h00);
        vecs[3]  = mk(0, 1, 8'h04, 1, 0, 0, 3'd0, 0, 8'h04);
        // Grant lasts one cycle. Ready while idle does nothing.
        vecs[4]  = mk(0, 0, 8'h00, 1, 0, 0, 3'd0, 0, 8'h00);
        // Enable low: the request is not captured or remembered.
        vecs[5]  = mk(0, 0, 8'h02, 0, 0, 0, 3'd0, 0, 8'h00);
        vecs[6]  = mk(0, 0, 8'h02, 0, 0, 0, 3'd0, 0, 8'h00);
        vecs[7]  = mk(0, 0, 8'h02, 0, 0, 0, 3'd0, 0, 8'h00);
        // Capture index 1. R then changes while Ready is low, and A holds.
        vecs[8]  = mk(0, 1, 8'h02, 0, 1, 1, 3'd1, 0, 8'h00);
        vecs[9]  = mk(0, 1, 8'h80, 0, 1, 1, 3'd1, 0, 8'h00);
        vecs[10] = mk(0, 1, 8'h80, 0, 1, 1, 3'd1, 0, 8'h00);
        vecs[11] = mk(0, 1, 8'h80, 0, 1, 1, 3'd1, 0, 8'h00);
        vecs[12] = mk(0, 1, 8'h80, 0, 1, 1, 3'd1, 0, 8'h00);
        // Accept with the request already dropped. P becomes 2.
        vecs[13] = mk(0, 0, 8'h00, 1, 0, 0, 3'd0, 0, 8'h02);
        // Reset. P returns to 0; a stale P of 2 would pick index 2 next.
        vecs[14] = mk(1, 1, 8'h85, 1, 0, 1, 3'd0, 0, 8'h00);
        // Contention on 10000101 with Ready held high.
        vecs[15] = mk(0, 1, 8'h85, 1, 1, 1, 3'd0, 1, 8'h00);
        vecs[16] = mk(0, 1, 8'h85, 1, 0, 0, 3'd0, 0, 8'h01);
        vecs[17] = mk(0, 1, 8'h85, 1, 1, 1, RR ? 3'd2 : 3'd0, 1, 8'h00);
        vecs[18] = mk(0, 1, 8'h85, 1, 0, 0, 3'd0, 0, RR ? 8'h04 : 8'h01);
        vecs[19] = mk(0, 1, 8'h85, 1, 1, 1, RR ? 3'd7 : 3'd0, 1, 8'h00);
        vecs[20] = mk(0, 1, 8'h85, 1, 0, 0, 3'd0, 0, RR ? 8'h80 : 8'h01);
        vecs[21] = mk(0, 1, 8'h85, 1, 1, 1, 3'd0, 1, 8'h00);
        vecs[22] = mk(0, 1, 8'h85, 1, 0, 0, 3'd0, 0, 8'h01);
        // Grant index 7, so P wraps to 0. Then 00000011 selects index 0.
        vecs[23] = mk(0, 1, 8'h80, 1, 1, 1, 3'd7, 0, 8'h00);
        vecs[24] = mk(0, 1, 8'h80, 1, 0, 0, 3'd0, 0, 8'h80);
        vecs[25] = mk(0, 1, 8'h03, 1, 1, 1, 3'd0, 1, 8'h00);
        vecs[26] = mk(0, 1, 8'h03, 1, 0, 0, 3'd0, 0, 8'h01);
        // Hold index 5, then reset with Ready high. The index is discarded
        // and no Grant is issued.
        vecs[27] = mk(0, 1, 8'h20, 0, 1, 1, 3'd5, 0, 8'h00);
        vecs[28] = mk(1, 1, 8'h20, 1, 0, 1, 3'd0, 0, 8'h00);
        vecs[29] = mk(0, 1, 8'h30, 0, 1, 1, 3'd4, 1, 8'h00);
        vecs[30] = mk(0, 0, 8'h00, 1, 0, 0, 3'd0, 0, 8'h10);
        vecs[31] = mk(0, 0, 8'h00, 0, 0, 0, 3'd0, 0, 8'h00);

        reset = 1'b1; Enable = 1'b0; R = 8'h00; Ready = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            reset  = vecs[i].rst;
            Enable = vecs[i].en;
            R      = vecs[i].r;
            Ready  = vecs[i].rdy;
            tick();
            $display("row %0d rst=%0b en=%0b R=%02h rdy=%0b -> A=%0d Valid=%0b Multi=%0b Grant=%02h",
                     i, reset, Enable, R, Ready, A, Valid, Multi, Grant);
            check("valid", i, {7'd0, Valid}, {7'd0, vecs[i].ev});
            check("grant", i, Grant, vecs[i].eg);
            if (vecs[i].chk_a) begin
                check("a",     i, {5'd0, A},     {5'd0, vecs[i].ea});
                check("multi", i, {7'd0, Multi}, {7'd0, vecs[i].em});
            end
        end

        // Hand-written: no combinational path. Changing the inputs between
        // edges must leave every output unchanged.
        reset = 1'b0; Enable = 1'b1; R = 8'h01; Ready = 1'b1;
        #2;
        check("comb_valid", 100, {7'd0, Valid}, 8'd0);
        check("comb_grant", 100, Grant, 8'd0);

        // Hand-written: bounded wait for Valid, then a one-cycle Grant.
        begin
            int n;
            n = 0;
            Ready = 1'b0;
            while (!Valid && n < 4) begin
                tick();
                n++;
            end
            check("wait_valid", 101, {7'd0, Valid}, 8'd1);
            $display("seq capture after %0d cycles A=%0d", n, A);
            check("seq_a", 101, {5'd0, A}, 8'd0);
            Enable = 1'b0; R = 8'h00; Ready = 1'b1;
            tick();
            $display("seq accept Grant=%02h Valid=%0b", Grant, Valid);
            check("seq_grant", 102, Grant, 8'h01);
            Ready = 1'b0;
            tick();
            $display("seq after Grant=%02h", Grant);
            check("seq_grant_off", 103, Grant, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
